// File: rtl/pixel_write_arbiter.sv
// Two-source round-robin pixel write arbiter with off-screen clipping and a
// FIFO that drains one pixel per cycle into the VGA adapter write port.
module pixel_write_arbiter #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          src0_valid,
  input  logic [14:0]   src0_coordinates,
  input  logic [8:0]    src0_colour,
  output logic          src0_ready,
  input  logic          src1_valid,
  input  logic [14:0]   src1_coordinates,
  input  logic [8:0]    src1_colour,
  output logic          src1_ready,
  input  logic          hold,
  input  logic          flush,
  output logic [7:0]    vga_x,
  output logic [6:0]    vga_y,
  output logic [8:0]    vga_colour,
  output logic          vga_plot,
  output logic [AW:0]   fifo_count,
  output logic [7:0]    clip_count
);

  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO   = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    SCREEN_W_C = 8'(SCREEN_W);
  localparam logic [6:0]    SCREEN_H_C = 7'(SCREEN_H);

  // A pixel is drawable only when both coordinates fall inside the screen.
  function automatic logic on_screen(input logic [14:0] coord);
    return (coord[14:7] < SCREEN_W_C) && (coord[6:0] < SCREEN_H_C);
  endfunction

  logic [23:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          last_grant_r;
  logic [7:0]    clip_r;
  logic [7:0]    vga_x_r;
  logic [6:0]    vga_y_r;
  logic [8:0]    vga_colour_r;
  logic          vga_plot_r;

  logic          space_s;
  logic          ready0_s;
  logic          ready1_s;
  logic          accept_s;
  logic          visible_s;
  logic          push_s;
  logic          pop_s;
  logic [14:0]   sel_coord_s;
  logic [8:0]    sel_colour_s;
  logic [23:0]   head_s;

  // Grant selection: on contention the source that did not win last time goes.
  always_comb begin
    space_s  = (count_r < DEPTH_C) && !flush;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if (src0_valid && src1_valid) begin
      if (last_grant_r) begin
        ready0_s = space_s;
      end else begin
        ready1_s = space_s;
      end
    end else if (src0_valid) begin
      ready0_s = space_s;
    end else if (src1_valid) begin
      ready1_s = space_s;
    end else begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end
  end

  assign src0_ready   = ready0_s;
  assign src1_ready   = ready1_s;
  assign accept_s     = ready0_s | ready1_s;
  assign sel_coord_s  = ready1_s ? src1_coordinates : src0_coordinates;
  assign sel_colour_s = ready1_s ? src1_colour : src0_colour;
  assign visible_s    = on_screen(sel_coord_s);
  assign push_s       = accept_s && visible_s;
  // Pop decision uses the start-of-cycle count, so a fresh push is never bypassed.
  assign pop_s        = !flush && !hold && (count_r != CNT_ZERO);
  assign head_s       = mem_r[rd_ptr_r];

  // Pixel storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {sel_coord_s, sel_colour_s};
    end
  end

  // FIFO pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Round-robin history and clip statistics survive a flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_r <= 1'b1;
      clip_r       <= 8'd0;
    end else begin
      if (accept_s) begin
        last_grant_r <= ready1_s;
      end
      if (accept_s && !visible_s && (clip_r != 8'hFF)) begin
        clip_r <= clip_r + 8'd1;
      end
    end
  end

  // VGA write port: one plot pulse per popped entry, coordinates held otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x_r      <= 8'd0;
      vga_y_r      <= 7'd0;
      vga_colour_r <= 9'd0;
      vga_plot_r   <= 1'b0;
    end else if (pop_s) begin
      vga_x_r      <= head_s[23:16];
      vga_y_r      <= head_s[15:9];
      vga_colour_r <= head_s[8:0];
      vga_plot_r   <= 1'b1;
    end else begin
      vga_plot_r   <= 1'b0;
    end
  end

  assign vga_x      = vga_x_r;
  assign vga_y      = vga_y_r;
  assign vga_colour = vga_colour_r;
  assign vga_plot   = vga_plot_r;
  assign fifo_count = count_r;
  assign clip_count = clip_r;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench for pixel_write_arbiter: a queue-based reference model
// predicts readies, occupancy, clip count and the stream of VGA writes.
module tb_pixel_write_arbiter;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        src0_valid = 1'b0, src1_valid = 1'b0;
  logic [14:0] src0_coordinates = 15'd0, src1_coordinates = 15'd0;
  logic [8:0]  src0_colour = 9'd0, src1_colour = 9'd0;
  logic        src0_ready, src1_ready;
  logic        hold = 1'b0, flush = 1'b0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot;
  logic [4:0]  fifo_count;
  logic [7:0]  clip_count;

  pixel_write_arbiter dut (
    .clk(clk), .resetn(resetn),
    .src0_valid(src0_valid), .src0_coordinates(src0_coordinates),
    .src0_colour(src0_colour), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_coordinates(src1_coordinates),
    .src1_colour(src1_colour), .src1_ready(src1_ready),
    .hold(hold), .flush(flush),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .fifo_count(fifo_count), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  pix_t m_fifo[$];
  pix_t exp_q[$];
  int   m_clip = 0;
  logic m_last = 1'b1;
  pix_t last_out = '0;
  logic acc0, acc1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the VGA port must match the next expected write, or stay idle.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("vga_plot", 32'(vga_plot), 32'd1);
        chk("vga_x", 32'(vga_x), 32'(e.x));
        chk("vga_y", 32'(vga_y), 32'(e.y));
        chk("vga_colour", 32'(vga_colour), 32'(e.c));
        last_out = e;
      end else begin
        chk("vga_plot_idle", 32'(vga_plot), 32'd0);
        chk("vga_x_hold", 32'(vga_x), 32'(last_out.x));
        chk("vga_colour_hold", 32'(vga_colour), 32'(last_out.c));
      end
    end
  end

  function automatic logic [14:0] mk(input int x, input int y);
    logic [7:0] xx;
    logic [6:0] yy;
    xx = 8'(x);
    yy = 7'(y);
    return {xx, yy};
  endfunction

  // One clock cycle: drive, check against the model, then advance the model past the edge.
  task automatic step(input logic v0, input logic [14:0] c0, input logic [8:0] k0,
                      input logic v1, input logic [14:0] c1, input logic [8:0] k1,
                      input logic h, input logic f);
    logic space, e0, e1;
    logic [14:0] c;
    pix_t p;
    @(negedge clk);
    src0_valid = v0; src0_coordinates = c0; src0_colour = k0;
    src1_valid = v1; src1_coordinates = c1; src1_colour = k1;
    hold = h; flush = f;
    #1;
    chk("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
    chk("clip_count", 32'(clip_count), 32'(m_clip));
    space = (m_fifo.size() < 16) && !f;
    e0 = v0 && space && (!v1 || m_last == 1'b1);
    e1 = v1 && space && (!v0 || m_last == 1'b0);
    chk("src0_ready", 32'(src0_ready), 32'(e0));
    chk("src1_ready", 32'(src1_ready), 32'(e1));
    acc0 = e0;
    acc1 = e1;
    if (f) begin
      m_fifo.delete();
    end else begin
      if (!h && m_fifo.size() > 0) exp_q.push_back(m_fifo.pop_front());
      if (e0 || e1) begin
        m_last = e1;
        c = e1 ? c1 : c0;
        p.x = c[14:7];
        p.y = c[6:0];
        p.c = e1 ? k1 : k0;
        if (int'(p.x) < 160 && int'(p.y) < 120) m_fifo.push_back(p);
        else if (m_clip < 255) m_clip++;
      end
    end
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) step(1'b0, 15'd0, 9'd0, 1'b0, 15'd0, 9'd0, h, 1'b0);
  endtask

  // Present one pixel on a source until it is accepted, bounded.
  task automatic send(input int src, input logic [14:0] c, input logic [8:0] k, input logic h);
    int n = 0;
    do begin
      if (src == 0) step(1'b1, c, k, 1'b0, 15'd0, 9'd0, h, 1'b0);
      else          step(1'b0, 15'd0, 9'd0, 1'b1, c, k, h, 1'b0);
      n++;
    end while (!(acc0 || acc1) && n < 64);
    if (!(acc0 || acc1)) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: src%0d not accepted after %0d cycles", src, n);
    end
  endtask

  initial begin
    logic have0, have1;
    logic [14:0] p0c, p1c;
    logic [8:0] p0k, p1k;
    int clip_before;

    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Reset state and single pixel latency
    idle(2, 1'b0);
    send(0, 15'h0A28, 9'h1C0, 1'b0);
    idle(3, 1'b0);

    // Contention: both valid continuously, grants must alternate
    for (int i = 0; i < 10; i++)
      step(1'b1, mk(i, i), 9'h0AA, 1'b1, mk(100 + i, 50), 9'h155, 1'b0, 1'b0);
    idle(4, 1'b0);

    // Clipping on source 1
    clip_before = m_clip;
    send(1, mk(160, 0), 9'h011, 1'b0);
    send(1, mk(0, 120), 9'h022, 1'b0);
    send(1, mk(159, 119), 9'h033, 1'b0);
    idle(3, 1'b0);
    chk("clip_plus_two", 32'(clip_count), 32'(clip_before + 2));

    // Full under hold: 20 pixels, only 16 fit
    for (int i = 0; i < 20; i++) begin
      step(1'b1, mk(i, 2 * i), 9'(i), 1'b0, 15'd0, 9'd0, 1'b1, 1'b0);
      if (!acc0) break;
    end
    chk("fifo_full", 32'(fifo_count), 32'd16);
    for (int i = 16; i < 20; i++) send(0, mk(i, 2 * i), 9'(i), 1'b0);
    idle(24, 1'b0);

    // Flush at occupancy 10
    for (int i = 0; i < 10; i++) send(0, mk(30 + i, 5), 9'h0F0, 1'b1);
    clip_before = m_clip;
    step(1'b1, mk(1, 1), 9'h001, 1'b1, mk(2, 2), 9'h002, 1'b1, 1'b1);
    idle(4, 1'b0);
    chk("fifo_after_flush", 32'(fifo_count), 32'd0);
    chk("clip_after_flush", 32'(clip_count), 32'(clip_before));

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 6; i++) send(0, mk(60 + i, 9), 9'h1A5, 1'b1);
    idle(2, 1'b0);
    @(negedge clk);
    src0_valid = 1'b0; src1_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_plot", 32'(vga_plot), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_vga_x", 32'(vga_x), 32'd0);
    m_fifo.delete();
    exp_q.delete();
    m_clip = 0;
    m_last = 1'b1;
    last_out = '0;
    @(negedge clk);
    resetn = 1'b1;
    step(1'b1, mk(7, 7), 9'h100, 1'b1, mk(8, 8), 9'h0FF, 1'b0, 1'b0);
    chk("first_grant_src0", 32'(acc0), 32'd1);
    idle(3, 1'b0);

    // Randomized traffic with sources holding their pixel until accepted
    have0 = 1'b0; have1 = 1'b0;
    p0c = 15'd0; p1c = 15'd0; p0k = 9'd0; p1k = 9'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!have0 && $urandom_range(0, 9) < 7) begin
        have0 = 1'b1;
        p0c = mk($urandom_range(0, 175), $urandom_range(0, 127));
        p0k = 9'($urandom);
      end
      if (!have1 && $urandom_range(0, 9) < 6) begin
        have1 = 1'b1;
        p1c = mk($urandom_range(0, 175), $urandom_range(0, 127));
        p1k = 9'($urandom);
      end
      step(have0, p0c, p0k, have1, p1c, p1k,
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 2));
      if (acc0) have0 = 1'b0;
      if (acc1) have1 = 1'b0;
    end
    idle(20, 1'b0);
    chk("final_drained", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
